// File: rtl/mmio_pkg.sv
// Shared types and constants for the FemtoRV32 MMIO interconnect.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  function automatic int slice_w(input int hi, input int lo);
    return hi - lo + 1;
  endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Base/mask address decoder: lowest-index hit wins, optional fallback slot on a miss.
module mmio_addr_match
  import mmio_pkg::*;
#(
  parameter int N_SLOTS      = 8,
  parameter int W            = 16,
  parameter int IDX_W        = 3,
  parameter int DEFAULT_SLOT = 0,
  parameter bit USE_DEFAULT  = 1'b1
) (
  input  logic [W-1:0]         field,
  input  logic [N_SLOTS*W-1:0] base,
  input  logic [N_SLOTS*W-1:0] mask,
  output logic [N_SLOTS-1:0]   sel,
  output logic [IDX_W-1:0]     idx,
  output logic                 miss
);

  logic [N_SLOTS-1:0] hit;

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      hit[i] = ((field ^ base[i*W +: W]) & mask[i*W +: W]) == '0;
    end
  end

  // Scan downward so the lowest matching slot is the last one written.
  always_comb begin
    sel  = '0;
    idx  = IDX_W'(DEFAULT_SLOT);
    miss = 1'b1;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx  = IDX_W'(i);
        miss = 1'b0;
      end
    end
    if (!miss) begin
      sel[idx] = 1'b1;
    end else if (USE_DEFAULT) begin
      sel[DEFAULT_SLOT] = 1'b1;
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// FemtoRV32 data-port interconnect: slot decode, read-return tracking,
// busy aggregation, bus timeout and a sticky error register.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int N_SLOTS = 8,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 16,
  parameter logic [N_SLOTS*slice_w(SEL_HI, SEL_LO)-1:0] SLOT_BASE =
    {16'h0080, 16'h0070, 16'h0060, 16'h0050, 16'h0030, 16'h0040, 16'h0001, 16'h0000},
  parameter logic [N_SLOTS*slice_w(SEL_HI, SEL_LO)-1:0] SLOT_MASK = '1,
  parameter int DEFAULT_SLOT = 0,
  parameter bit USE_DEFAULT  = 1'b1,
  parameter int TIMEOUT      = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  input  logic [3:0]                m_wmask,
  input  logic                      m_rstrb,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_rbusy,
  output logic                      m_wbusy,
  output logic [N_SLOTS-1:0]        s_rd,
  output logic [N_SLOTS-1:0]        s_wr,
  input  logic [N_SLOTS*DATA_W-1:0] s_rdata,
  input  logic [N_SLOTS-1:0]        s_rbusy,
  input  logic [N_SLOTS-1:0]        s_wbusy,
  input  logic                      err_clr,
  output logic                      err,
  output logic [ADDR_W-1:0]         err_addr
);

  localparam int W     = slice_w(SEL_HI, SEL_LO);
  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  logic [N_SLOTS-1:0] sel;
  logic [IDX_W-1:0]   idx;
  logic               miss;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               timed_out;
  logic               miss_rd;
  logic [ADDR_W-1:0]  acc_addr;
  logic               wr_req;
  logic               routed;
  logic               miss_err;
  logic               timeout_hit;
  logic               unused_ok;

  mmio_addr_match #(
    .N_SLOTS(N_SLOTS),
    .W(W),
    .IDX_W(IDX_W),
    .DEFAULT_SLOT(DEFAULT_SLOT),
    .USE_DEFAULT(USE_DEFAULT)
  ) u_match (
    .field(m_addr[SEL_HI:SEL_LO]),
    .base(SLOT_BASE),
    .mask(SLOT_MASK),
    .sel(sel),
    .idx(idx),
    .miss(miss)
  );

  // Write data goes to the slots on the shared bus, not through this block.
  assign unused_ok = ^m_wdata;

  assign wr_req      = |m_wmask;
  assign routed      = !miss || USE_DEFAULT;
  assign miss_err    = miss && !USE_DEFAULT && (m_rstrb || wr_req);
  assign timeout_hit = (TIMEOUT > 0) && (state != IDLE) && (cnt == TO_VAL);

  assign s_rd = m_rstrb ? sel : '0;
  assign s_wr = wr_req  ? sel : '0;

  assign m_rbusy = (state == RD_WAIT) && s_rbusy[rd_idx] && !timeout_hit;
  // A combined read+write tracks the read, so the write busy is passed through directly.
  assign m_wbusy = ((state == WR_WAIT) && s_wbusy[wr_idx] && !timeout_hit) ||
                   (m_rstrb && wr_req && routed && s_wbusy[idx]);
  assign m_rdata = (timed_out || miss_rd) ? ERR_DATA : s_rdata[rd_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_idx    <= IDX_W'(DEFAULT_SLOT);
      wr_idx    <= IDX_W'(DEFAULT_SLOT);
      timed_out <= 1'b0;
      miss_rd   <= 1'b0;
      acc_addr  <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (m_rstrb) begin
        timed_out <= 1'b0;
        miss_rd   <= 1'b0;
      end
      if (m_rstrb && routed) begin
        state    <= RD_WAIT;
        rd_idx   <= idx;
        cnt      <= '0;
        acc_addr <= m_addr;
        if (wr_req) begin
          wr_idx <= idx;
        end
      end else if (wr_req && routed) begin
        state    <= WR_WAIT;
        wr_idx   <= idx;
        cnt      <= '0;
        acc_addr <= m_addr;
      end else begin
        if (m_rstrb) begin
          miss_rd <= 1'b1;
        end
        case (state)
          RD_WAIT: begin
            if (timeout_hit) begin
              state     <= IDLE;
              timed_out <= 1'b1;
            end else if (s_rbusy[rd_idx]) begin
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          WR_WAIT: begin
            if (timeout_hit) begin
              state     <= IDLE;
              timed_out <= 1'b1;
            end else if (s_wbusy[wr_idx]) begin
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A new error beats a simultaneous clear and re-captures the address.
      if (miss_err || timeout_hit) begin
        err <= 1'b1;
        if (!err || err_clr) begin
          err_addr <= miss_err ? m_addr : acc_addr;
        end
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Testbench for mmio_interconnect: dut_a falls back to slot 0 on a miss,
// dut_b flags misses as errors and uses a masked slot for priority decode.
module tb_mmio_interconnect;

  localparam logic [127:0] BASE_A =
    {16'h0080, 16'h0070, 16'h0060, 16'h0050, 16'h0030, 16'h0040, 16'h0001, 16'h0000};
  localparam logic [127:0] BASE_B =
    {16'h0080, 16'h0070, 16'h0060, 16'h1234, 16'h1200, 16'h0040, 16'h0001, 16'h0000};
  localparam logic [127:0] MASK_B =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic         clk;
  logic         rst;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wmask;
  logic         m_rstrb;
  logic [255:0] s_rdata;
  logic [7:0]   s_rbusy;
  logic [7:0]   s_wbusy;
  logic         err_clr;

  logic [31:0]  a_m_rdata, b_m_rdata;
  logic         a_m_rbusy, b_m_rbusy;
  logic         a_m_wbusy, b_m_wbusy;
  logic [7:0]   a_s_rd, b_s_rd;
  logic [7:0]   a_s_wr, b_s_wr;
  logic         a_err, b_err;
  logic [31:0]  a_err_addr, b_err_addr;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt;

  mmio_interconnect #(
    .SLOT_BASE(BASE_A), .USE_DEFAULT(1'b1), .TIMEOUT(15)
  ) dut_a (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rstrb(m_rstrb), .m_rdata(a_m_rdata), .m_rbusy(a_m_rbusy), .m_wbusy(a_m_wbusy),
    .s_rd(a_s_rd), .s_wr(a_s_wr), .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .err_clr(err_clr), .err(a_err), .err_addr(a_err_addr)
  );

  mmio_interconnect #(
    .SLOT_BASE(BASE_B), .SLOT_MASK(MASK_B), .USE_DEFAULT(1'b0), .TIMEOUT(15)
  ) dut_b (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rstrb(m_rstrb), .m_rdata(b_m_rdata), .m_rbusy(b_m_rbusy), .m_wbusy(b_m_wbusy),
    .s_rd(b_s_rd), .s_wr(b_s_wr), .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .err_clr(err_clr), .err(b_err), .err_addr(b_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        err_b;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic applyStimulus(input logic [31:0] addr, input logic rstrb, input logic [3:0] wmask);
    @(negedge clk);
    m_addr  = addr;
    m_rstrb = rstrb;
    m_wmask = wmask;
    m_wdata = addr ^ 32'h5A5A5A5A;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Slot i returns A000000i unless a sequence overrides it.
    for (int i = 0; i < 8; i++) s_rdata[i*32 +: 32] = 32'hA0000000 + i;
    vecs[0] = '{32'h00010004, 1'b1, 4'h0, 8'h02, 8'h02, 32'hA0000001, 32'hA0000001, 1'b0};
    vecs[1] = '{32'h00400000, 1'b0, 4'h1, 8'h04, 8'h04, 32'h0,        32'h0,        1'b0};
    vecs[2] = '{32'h00990000, 1'b1, 4'h0, 8'h01, 8'h00, 32'hA0000000, ERRD,         1'b1};
    vecs[3] = '{32'h00300010, 1'b0, 4'hF, 8'h08, 8'h00, 32'h0,        32'h0,        1'b1};
    vecs[4] = '{32'h12340000, 1'b1, 4'h0, 8'h01, 8'h08, 32'hA0000000, 32'hA0000003, 1'b1};
    vecs[5] = '{32'h12AB0000, 1'b1, 4'h0, 8'h01, 8'h08, 32'hA0000000, 32'hA0000003, 1'b1};
    vecs[6] = '{32'h00800000, 1'b1, 4'hC, 8'h80, 8'h80, 32'hA0000007, 32'hA0000007, 1'b1};
    vecs[7] = '{32'h00000000, 1'b1, 4'h0, 8'h01, 8'h01, 32'hA0000000, 32'hA0000000, 1'b1};
    vecs[8] = '{32'h00500000, 1'b0, 4'h0, 8'h10, 8'h00, 32'h0,        32'h0,        1'b1};

    rst = 1'b1; m_addr = '0; m_wdata = '0; m_wmask = '0; m_rstrb = 1'b0;
    s_rbusy = '0; s_wbusy = '0; err_clr = 1'b0;
    #1;
    checkOutput("reset m_rbusy", {31'b0, a_m_rbusy}, 32'd0);
    checkOutput("reset m_wbusy", {31'b0, a_m_wbusy}, 32'd0);
    checkOutput("reset s_rd", {24'b0, a_s_rd}, 32'd0);
    checkOutput("reset s_wr", {24'b0, a_s_wr}, 32'd0);
    checkOutput("reset err", {31'b0, a_err}, 32'd0);
    checkOutput("reset err_addr", a_err_addr, 32'd0);
    checkOutput("reset m_rdata", a_m_rdata, 32'hA0000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] decode vector table");
    for (int k = 0; k < NV; k++) begin
      applyStimulus(vecs[k].addr, vecs[k].rstrb, vecs[k].wmask);
      checkOutput($sformatf("v%0d a s_rd", k), {24'b0, a_s_rd}, vecs[k].rstrb ? {24'b0, vecs[k].sel_a} : 32'd0);
      checkOutput($sformatf("v%0d a s_wr", k), {24'b0, a_s_wr}, (|vecs[k].wmask) ? {24'b0, vecs[k].sel_a} : 32'd0);
      checkOutput($sformatf("v%0d b s_rd", k), {24'b0, b_s_rd}, vecs[k].rstrb ? {24'b0, vecs[k].sel_b} : 32'd0);
      checkOutput($sformatf("v%0d b s_wr", k), {24'b0, b_s_wr}, (|vecs[k].wmask) ? {24'b0, vecs[k].sel_b} : 32'd0);
      stepCycle();
      m_rstrb = 1'b0;
      m_wmask = '0;
      #1;
      checkOutput($sformatf("v%0d a err", k), {31'b0, a_err}, 32'd0);
      checkOutput($sformatf("v%0d b err", k), {31'b0, b_err}, {31'b0, vecs[k].err_b});
      checkOutput($sformatf("v%0d b rbusy", k), {31'b0, b_m_rbusy}, 32'd0);
      if (vecs[k].rstrb) begin
        checkOutput($sformatf("v%0d a rdata", k), a_m_rdata, vecs[k].rd_a);
        checkOutput($sformatf("v%0d b rdata", k), b_m_rdata, vecs[k].rd_b);
      end
      stepCycle();
    end
    checkOutput("miss err_addr", b_err_addr, 32'h00990000);

    // Clear and new miss in the same cycle: the error wins.
    err_clr = 1'b1;
    applyStimulus(32'h00AA0000, 1'b1, 4'h0);
    stepCycle();
    err_clr = 1'b0; m_rstrb = 1'b0;
    #1;
    checkOutput("clr+miss err", {31'b0, b_err}, 32'd1);
    checkOutput("clr+miss err_addr", b_err_addr, 32'h00AA0000);
    @(negedge clk); err_clr = 1'b1;
    stepCycle();
    err_clr = 1'b0;
    checkOutput("clear err", {31'b0, b_err}, 32'd0);
    stepCycle();

    $display("[TB] read with 3 busy cycles");
    s_rdata[32 +: 32] = 32'h12345678;
    applyStimulus(32'h00010004, 1'b1, 4'h0);
    s_rbusy = 8'h02;
    #1;
    checkOutput("rd strobe", {24'b0, a_s_rd}, 32'h02);
    stepCycle();
    m_rstrb = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("rd busy c%0d", c), {31'b0, a_m_rbusy}, 32'd1);
      checkOutput($sformatf("rd no restrobe c%0d", c), {24'b0, a_s_rd}, 32'd0);
      stepCycle();
    end
    s_rbusy = '0;
    m_addr = 32'h00400000;
    #1;
    checkOutput("rd busy drop", {31'b0, a_m_rbusy}, 32'd0);
    checkOutput("rd data", a_m_rdata, 32'h12345678);
    stepCycle();
    checkOutput("rd data stable", a_m_rdata, 32'h12345678);
    s_rdata[32 +: 32] = 32'hA0000001;

    $display("[TB] write to slot 2");
    applyStimulus(32'h00400000, 1'b0, 4'b0001);
    s_wbusy = 8'h04;
    #1;
    checkOutput("wr strobe", {24'b0, a_s_wr}, 32'h04);
    checkOutput("wr no rd", {24'b0, a_s_rd}, 32'h00);
    stepCycle();
    m_wmask = '0;
    #1;
    checkOutput("wr busy 1", {31'b0, a_m_wbusy}, 32'd1);
    stepCycle();
    checkOutput("wr busy 2", {31'b0, a_m_wbusy}, 32'd1);
    s_wbusy = '0;
    #1;
    checkOutput("wr busy drop", {31'b0, a_m_wbusy}, 32'd0);
    checkOutput("wr err", {31'b0, a_err}, 32'd0);
    stepCycle();

    $display("[TB] read and write together");
    applyStimulus(32'h00800000, 1'b1, 4'b1100);
    s_wbusy = 8'h80;
    #1;
    checkOutput("rw wbusy", {31'b0, a_m_wbusy}, 32'd1);
    checkOutput("rw s_wr", {24'b0, a_s_wr}, 32'h80);
    stepCycle();
    m_rstrb = 1'b0; m_wmask = '0; s_wbusy = '0;
    stepCycle();

    $display("[TB] timeout after 15 busy cycles");
    m_addr = 32'h00010004;
    applyStimulus(32'h00010004, 1'b1, 4'h0);
    s_rbusy = 8'h02;
    stepCycle();
    m_rstrb = 1'b0;
    #1;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!a_m_rbusy) break;
      busy_cnt++;
      stepCycle();
    end
    checkOutput("timeout busy cycles", busy_cnt, 32'd15);
    stepCycle();
    checkOutput("timeout rbusy", {31'b0, a_m_rbusy}, 32'd0);
    checkOutput("timeout rdata", a_m_rdata, ERRD);
    checkOutput("timeout err", {31'b0, a_err}, 32'd1);
    checkOutput("timeout err_addr", a_err_addr, 32'h00010004);
    s_rbusy = '0;
    @(negedge clk); err_clr = 1'b1;
    stepCycle();
    err_clr = 1'b0;
    checkOutput("timeout clear", {31'b0, a_err}, 32'd0);
    applyStimulus(32'h00010004, 1'b1, 4'h0);
    stepCycle();
    m_rstrb = 1'b0;
    #1;
    checkOutput("post-timeout rdata", a_m_rdata, 32'hA0000001);
    stepCycle();

    $display("[TB] reset during RD_WAIT");
    applyStimulus(32'h00010004, 1'b1, 4'h0);
    s_rbusy = 8'h02;
    stepCycle();
    m_rstrb = 1'b0;
    #1;
    checkOutput("pre-reset rbusy", {31'b0, a_m_rbusy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset rbusy", {31'b0, a_m_rbusy}, 32'd0);
    checkOutput("reset s_rd", {24'b0, a_s_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_rbusy = '0;
    applyStimulus(32'h00400000, 1'b1, 4'h0);
    stepCycle();
    m_rstrb = 1'b0;
    #1;
    checkOutput("post-reset rdata", a_m_rdata, 32'hA0000002);
    checkOutput("post-reset rbusy", {31'b0, a_m_rbusy}, 32'd0);
    stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_interconnect.md
Name: mmio_interconnect

Overview:
- Parametrised memory-mapped interconnect between the FemtoRV32 data port and N peripheral slots.
- Replaces the hand-written chip-select case and read-data mux in the SoC top.
- Adds per-slot base/mask decode, read-return tracking, busy aggregation, a bus timeout and a sticky error register for unmapped or hung accesses.

Parameters:
- N_SLOTS, 8, number of peripheral slots (1..16)
- SEL_HI, 31, MSB of address field used for decode
- SEL_LO, 16, LSB of address field used for decode
- SLOT_BASE, {16'h0000,16'h0001,16'h0040,...}, flattened N_SLOTS*(SEL_HI-SEL_LO+1) base values, slot i at bits [i*W +: W]
- SLOT_MASK, all ones, flattened compare masks, same layout
- DEFAULT_SLOT, 0, slot used on decode miss when USE_DEFAULT=1
- USE_DEFAULT, 1, 1: miss routes to DEFAULT_SLOT; 0: miss is a bus error
- TIMEOUT, 1023, max busy cycles before abort; 0 disables the timeout
- ERR_DATA, 32'hDEADBEEF, read data returned on an error or timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_addr  in  32  CPU address
- m_wdata  in  32  CPU write data
- m_wmask  in  4  CPU byte write mask
- m_rstrb  in  1  CPU read strobe (one cycle)
- m_rdata  out  32  read data to CPU
- m_rbusy  out  1  read busy to CPU
- m_wbusy  out  1  write busy to CPU
- s_rd  out  N_SLOTS  per-slot read strobe: m_rstrb & sel[i]
- s_wr  out  N_SLOTS  per-slot write strobe: |m_wmask & sel[i]
- s_rdata  in  N_SLOTS*32  flattened slot read data
- s_rbusy  in  N_SLOTS  per-slot read busy
- s_wbusy  in  N_SLOTS  per-slot write busy
- err_clr  in  1  clears the sticky error
- err  out  1  sticky bus error flag
- err_addr  out  32  address of the first error since the last clear

Behaviour:
- Decode (combinational): hit[i] = ((m_addr[SEL_HI:SEL_LO] ^ base_i) & mask_i) == 0. The lowest-index hit wins, giving a one-hot sel.
- Decode miss:
  - USE_DEFAULT=1: sel = DEFAULT_SLOT.
  - USE_DEFAULT=0: sel = 0, no strobes are issued, the access is flagged as an error.
- Strobes, address and wdata reach the slots in the same cycle; the block adds no latency.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE, m_rstrb with a hit: latch rd_idx <= sel index, cnt <= 0, go to RD_WAIT.
  - IDLE, write with a hit: latch wr_idx, cnt <= 0, go to WR_WAIT.
  - RD_WAIT: while s_rbusy[rd_idx]=1, increment cnt. When s_rbusy[rd_idx]=0, go to IDLE.
  - WR_WAIT: same as RD_WAIT, using s_wbusy[wr_idx].
  - Timeout: cnt == TIMEOUT (TIMEOUT>0) forces IDLE, sets timed_out, err <= 1 and captures err_addr if err was 0.
- m_rbusy = (state==RD_WAIT) & s_rbusy[rd_idx] & ~timeout_hit. m_wbusy is the same using the write path.
- m_rdata:
  - timed_out or miss_rd set: ERR_DATA.
  - otherwise: s_rdata[rd_idx]. Because rd_idx is registered, the data is stable even if m_addr changes after the strobe.
  - timed_out and miss_rd clear on the next m_rstrb.
- Miss read (USE_DEFAULT=0): m_rbusy stays 0, miss_rd <= 1 (ERR_DATA from the next cycle), err is set.
- Miss write: dropped, m_wbusy=0, err is set.
- Read and write in the same cycle: both strobes are forwarded. The FSM enters RD_WAIT and m_wbusy = s_wbusy[sel] combinationally for that cycle.
- A strobe arriving while in RD_WAIT/WR_WAIT is forwarded and restarts tracking with the new index; cnt resets.
- err_clr and a new error in the same cycle: the error wins, err stays 1 and err_addr is updated.
- Reset values: state IDLE, cnt 0, rd_idx=wr_idx=DEFAULT_SLOT, timed_out 0, miss_rd 0, err 0, err_addr 0. Hence m_rbusy 0, m_wbusy 0, all s_rd/s_wr 0 when CPU strobes are low.
- Reset asserted mid-access drops tracking immediately. The slot sees no further strobes.
- cnt width is clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Package mmio_pkg holds:
  - state encoding (IDLE/RD_WAIT/WR_WAIT)
  - DATA_W=32, ADDR_W=32
  - default ERR_DATA
  - a helper function for the flattened slice width
- One combinational sub-module, mmio_addr_match: address plus base/mask vectors in; one-hot sel, index and miss out.

Test Plan:
- Read 0x00010004 with slot1 base 0x0001 and s_rbusy[1] high for 3 cycles, s_rdata[1]=0x12345678 -> s_rd[1] pulses once, m_rbusy high for 3 cycles, then m_rdata=0x12345678.
- Write wmask=4'b0001 to 0x00400000 (slot2) -> s_wr[2]=1 only, m_wbusy follows s_wbusy[2], err stays 0.
- USE_DEFAULT=0, read 0x00990000 -> no s_rd bit set, m_rbusy 0, m_rdata=0xDEADBEEF, err=1, err_addr=0x00990000.
- USE_DEFAULT=1, same read -> routed to slot0, err=0.
- TIMEOUT=15, s_rbusy[1] held high -> m_rbusy drops after 15 busy cycles, m_rdata=ERR_DATA, err=1. Pulse err_clr -> err=0.
- Assert rst during RD_WAIT -> m_rbusy=0 the same cycle, state IDLE. A new read after reset completes normally.
